// File: rtl/cpu_pkg.sv
// Shared types and constants for the MIPS core front end.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, decode handshake and control.
interface instr_fetch_unit_if;
  import cpu_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_data;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            halt;
  logic            halted;
  logic            fault;

  modport master (
    output imem_addr,
    input  imem_data,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc,
    input  redirect_valid,
    input  redirect_pc,
    input  halt,
    output halted,
    output fault
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc,
    output redirect_valid,
    output redirect_pc,
    output halt,
    input  halted,
    input  fault
  );

endinterface

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// Two-slot fetch FIFO built as a shift pair so the head slot holds its
// last value once the buffer runs empty.
module fetch_buffer
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t tail;
  logic [1:0]   cnt_after_pop;

  assign cnt_after_pop = count - {1'b0, pop};

  // New entries land in the first slot left free after this cycle's pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      count <= cnt_after_pop + {1'b0, push};
      if (pop && (count == 2'd2)) begin
        head <= tail;
      end
      if (push) begin
        if (cnt_after_pop == 2'd0) begin
          head <= din;
        end else begin
          tail <= din;
        end
      end
    end
  end

  assign full  = (count == 2'(DEPTH));
  assign empty = (count == 2'd0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory and feeds decode
// through a two-entry buffer; handles redirect, halt and range faults.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned     MEM_WORDS = 64,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);

  fetch_state_e    state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic            push, pop, flush;
  logic            buf_full, buf_empty;
  logic [1:0]      buf_count;
  logic            in_range;
  fetch_entry_t    head;
  fetch_entry_t    din;

  assign in_range = (pc[XLEN-1:2] < 30'(MEM_WORDS));
  assign pop      = !buf_empty && bus.if_ready;
  assign din      = '{pc: pc, instr: bus.imem_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

  // Redirect outranks halt and range check; misaligned targets fault with pc held.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    push    = 1'b0;
    flush   = 1'b0;
    case (state)
      RUN: begin
        if (bus.redirect_valid) begin
          flush = 1'b1;
          if (bus.redirect_pc[1:0] != 2'b00) begin
            state_n = FAULT;
          end else begin
            pc_n = bus.redirect_pc;
            if (bus.halt) state_n = HALTED;
          end
        end else if (bus.halt) begin
          state_n = HALTED;
        end else if (!in_range) begin
          state_n = FAULT;
        end else if (!buf_full || pop) begin
          push = 1'b1;
          pc_n = pc + 32'd4;
        end
      end
      HALTED:  state_n = HALTED;
      FAULT:   state_n = FAULT;
      default: state_n = FAULT;
    endcase
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .count (buf_count),
    .full  (buf_full),
    .empty (buf_empty)
  );

  assign bus.imem_addr = {2'b00, pc[XLEN-1:2]};
  assign bus.if_valid  = !buf_empty;
  assign bus.if_instr  = head.instr;
  assign bus.if_pc     = head.pc;
  assign bus.halted    = (state == HALTED);
  assign bus.fault     = (state == FAULT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a queue-based reference model.
module tb_instr_fetch_unit;

  localparam int unsigned MWORDS  = 64;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam int          M_RUN   = 0;
  localparam int          M_HALT  = 1;
  localparam int          M_FAULT = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk;
  logic rst;
  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC  (RST_PC),
    .MEM_WORDS (MWORDS),
    .BUF_DEPTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [31:0] mem [MWORDS];

  assign bus.imem_data = (bus.imem_addr < 32'(MWORDS)) ? mem[bus.imem_addr[5:0]] : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  ent_t        q[$];
  logic [31:0] m_pc;
  int          m_st;
  logic [31:0] sh_pc;
  logic [31:0] sh_instr;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // Next-state of the model from the rules, using the inputs about to be sampled.
  task automatic model_step();
    if (rst) begin
      q.delete();
      m_pc     = RST_PC;
      m_st     = M_RUN;
      sh_pc    = 32'h0;
      sh_instr = 32'h0;
      return;
    end
    if (q.size() > 0 && bus.if_ready) void'(q.pop_front());
    if (m_st == M_RUN) begin
      if (bus.redirect_valid) begin
        q.delete();
        if (bus.redirect_pc % 4 != 0) m_st = M_FAULT;
        else begin
          m_pc = bus.redirect_pc;
          if (bus.halt) m_st = M_HALT;
        end
      end else if (bus.halt) begin
        m_st = M_HALT;
      end else if (m_pc / 4 >= MWORDS) begin
        m_st = M_FAULT;
      end else if (q.size() < 2) begin
        q.push_back('{pc: m_pc, instr: mem[m_pc / 4]});
        m_pc = m_pc + 32'd4;
      end
    end
    if (q.size() > 0) begin
      sh_pc    = q[0].pc;
      sh_instr = q[0].instr;
    end
  endtask

  task automatic compare_all();
    check_eq("if_valid",  32'(bus.if_valid), 32'(q.size() > 0));
    check_eq("if_pc",     bus.if_pc, sh_pc);
    check_eq("if_instr",  bus.if_instr, sh_instr);
    check_eq("imem_addr", bus.imem_addr, m_pc >> 2);
    check_eq("halted",    32'(bus.halted), 32'(m_st == M_HALT));
    check_eq("fault",     32'(bus.fault), 32'(m_st == M_FAULT));
  endtask

  task automatic cyc(input logic r, input logic rdy, input logic rv,
                     input logic [31:0] rpc, input logic h);
    rst                = r;
    bus.if_ready       = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.halt           = h;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  function automatic logic [31:0] rand_target();
    int unsigned sel;
    sel = $urandom_range(0, 15);
    if (sel == 0)      return 32'(($urandom_range(0, 63) << 2) | $urandom_range(1, 3));
    else if (sel == 1) return 32'h0000_0200;
    else if (sel < 5)  return 32'(($urandom_range(56, 63)) << 2);
    else               return 32'(($urandom_range(0, 63)) << 2);
  endfunction

  initial begin
    int stuck;
    for (int i = 0; i < int'(MWORDS); i++) mem[i] = $urandom();
    mem[0] = 32'h0000_8821;
    mem[1] = 32'h0000_A821;
    mem[10] = 32'h2008_0005;
    rst = 1'b1;
    bus.if_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.halt = 1'b0;
    q.delete();
    m_pc = RST_PC; m_st = M_RUN; sh_pc = 0; sh_instr = 0;

    // reset, then streaming with decode always ready
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 0);
    check_eq("stream_last_pc", bus.if_pc, 32'h0000_001C);

    // backpressure fills the buffer, then pop and push coincide
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
    check_eq("full_imem_addr", bus.imem_addr, 32'd2);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);

    // redirect with two entries buffered
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h0000_0028, 0);
    cyc(0, 1, 0, 0, 0);
    check_eq("redir_instr", bus.if_instr, 32'h2008_0005);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);

    // misaligned redirect faults and freezes the pc
    cyc(0, 1, 1, 32'h0000_0006, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);

    // run off the end of memory
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 1, 32'h0000_00E0, 0);
    for (int i = 0; i < 14; i++) cyc(0, 1, 0, 0, 0);
    check_eq("end_fault", 32'(bus.fault), 32'd1);
    check_eq("end_last_pc", bus.if_pc, 32'h0000_00FC);

    // halt with one entry buffered, drain, then reset out of HALTED
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);

    // redirect and halt together
    cyc(0, 1, 1, 32'h0000_0040, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);

    // randomized traffic
    cyc(1, 0, 0, 0, 0);
    stuck = 0;
    for (int i = 0; i < 4000; i++) begin
      logic r, rdy, rv, h;
      r   = ($urandom_range(0, 199) == 0) || (stuck > 8);
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 19) == 0);
      h   = ($urandom_range(0, 59) == 0);
      cyc(r, rdy, rv, rand_target(), h);
      stuck = (m_st != M_RUN) ? stuck + 1 : 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the single-cycle/multicycle MIPS core.
- Owns the program counter and drives the word address into the instruction memory, which reads combinationally in the same cycle.
- Captures each {pc, instruction} pair into a 2-entry buffer and hands it to decode over a valid/ready handshake.
- Supports control-flow redirect (branch/jump), halt, and out-of-range fault detection.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset. Must be word aligned.
- MEM_WORDS, 64, number of instruction-memory words. A fetch at word index >= MEM_WORDS is a fault.
- BUF_DEPTH, 2, capacity of the fetch buffer. Fixed at 2; other values are not supported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- imem_addr  output  32  word index to instruction memory, equal to {2'b00, pc[31:2]}
- imem_data  input  32  instruction word, valid in the same cycle as imem_addr
- if_valid  output  1  buffer head holds a valid instruction
- if_ready  input  1  decode accepts the head this cycle
- if_instr  output  32  instruction at the buffer head
- if_pc  output  32  byte address of if_instr
- redirect_valid  input  1  load a new PC (taken branch or jump)
- redirect_pc  input  32  target byte address
- halt  input  1  stop fetching; sticky until rst
- halted  output  1  FSM is in HALTED
- fault  output  1  FSM is in FAULT

Behaviour:
- Reset, sampled on the clk edge while rst=1:
  - pc=RESET_PC, buffer emptied, state=RUN.
  - if_valid=0, if_instr=0, if_pc=0, halted=0, fault=0.
  - imem_addr = RESET_PC>>2.
  - rst asserted mid-operation discards all buffered entries in that same edge.
- FSM states:
  - RUN: normal fetch.
  - HALTED: no fetch. Exit only by rst.
  - FAULT: no fetch. Exit only by rst.
- Push condition (RUN): state==RUN, pc[31:2] < MEM_WORDS, and the buffer is not full after this cycle's pop. On push, {pc, imem_data} is written to the tail and pc <= pc+4. Throughput is one instruction per cycle when decode is always ready.
- Pop: if_valid && if_ready removes the head. Push and pop in the same cycle are legal, including when the buffer is full; count is unchanged.
- Latency: an instruction fetched at edge N appears at if_valid/if_instr from edge N onward, i.e. one registered cycle after imem_addr is presented.
- Full: count==2 with no pop means no push and the pc holds.
- Empty: if_valid=0 and if_instr/if_pc hold their last value.
- Redirect (RUN), highest priority apart from rst:
  - Buffer is flushed, including any entry that would have been pushed this cycle.
  - A pop in the same cycle is still counted as consumed by decode.
  - pc <= redirect_pc. Fetch from the new pc starts the next cycle.
  - If redirect_pc[1:0]!=0, go to FAULT instead and leave pc unchanged.
- Halt (RUN, halt=1, no redirect): no push this cycle and go to HALTED. Buffered entries still drain to decode.
- Redirect and halt in the same cycle: the redirect updates pc and flushes, then go to HALTED.
- Out of range (RUN, pc[31:2] >= MEM_WORDS, no redirect): no push and go to FAULT. The buffer still drains.
- In HALTED and FAULT, redirect_valid and halt are ignored.
- pc arithmetic is 32-bit modulo 2^32. Wrap past 0xFFFF_FFFC is never reached in practice because MEM_WORDS bounds it first.
- imem_addr is always {2'b00, pc[31:2]}, in every state.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN=32
  - fetch_state_e {RUN, HALTED, FAULT}
  - INSTR_NOP=32'h0000_0000
  - typedef fetch_entry_t {pc[31:0], instr[31:0]}
- One sub-module, fetch_buffer: a 2-entry FIFO of fetch_entry_t with push, pop and flush, synchronous rst, and count/full/empty outputs.
- The FSM and pc logic stay in instr_fetch_unit.

Test Plan:
- Reset then run with if_ready=1 and memory preloaded:
  - if_pc sequence 0, 4, 8, … one per cycle.
  - if_instr matches mem[0], mem[1], …, e.g. 32'h00008821 then 32'h0000A821.
- if_ready=0 for 5 cycles after reset:
  - Buffer fills to 2 and if_valid=1 with if_pc=0.
  - pc holds at 8 and imem_addr stays 2.
  - On the first if_ready=1 cycle the pop and push coincide and no instruction is lost or duplicated.
- Redirect to 32'h0000_0028 while the buffer holds 2 entries:
  - Next cycle if_valid=0.
  - The following cycle if_pc=0x28 and if_instr=mem[10].
- redirect_pc=32'h0000_0006 → fault=1 the next cycle, no further pushes, imem_addr frozen.
- Run sequentially to pc=0x100 with MEM_WORDS=64:
  - The last delivered if_pc is 0xFC.
  - fault=1 on the cycle pc reaches 0x100, after the buffer has drained.
- Assert halt for one cycle with 1 entry buffered:
  - halted=1 next cycle.
  - The entry still delivers with if_ready=1, then if_valid=0 permanently.
  - rst mid-halt restores RUN, pc=RESET_PC, halted=0.
